// File: rtl/mux_rr_n_pkg.sv
// Shared constants and helpers for the round-robin N:1 mux.
// Optional packet lock is enabled by defining MUX_RR_LOCK_EN.
`ifndef MUX_RR_N_PKG_SV
`define MUX_RR_N_PKG_SV

// Channel i of a flattened bus of W-bit lanes.
`define MUX_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package mux_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/mux_rr_n_if.sv
// Producer/consumer bundle for mux_rr_n: N flattened input lanes, one tagged output.
interface mux_rr_n_if
  import mux_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  localparam int SELW = clog2(N);

  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_last;
  logic            out_ready;

  // Mux side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  // Producers plus consumer side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

endinterface

// File: rtl/mux_rr_n_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int              t;
    logic [SELW-1:0] idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    t          = 0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      t = int'(ptr) + k;
      if (t >= N) t = t - N;
      idx = SELW'(t);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// Registered N:1 round-robin mux with valid/ready on every port and channel tagging.
// Define MUX_RR_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  mux_rr_n_if.slave bus
);

  localparam int SELW = clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    gnt_onehot;
  logic [SELW-1:0] gnt_idx;
  logic            any;
  logic            load;
  logic            xfer;
  logic [W-1:0]    gnt_data;
  logic            gnt_last;
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_next;
  logic            valid_q;
  logic [W-1:0]    data_q;
  logic [SELW-1:0] sel_q;
  logic            last_q;

`ifdef MUX_RR_LOCK_EN
  logic            locked_q;
  logic [SELW-1:0] lock_ch_q;

  // While a packet is open only its owner may be granted, even if it goes idle.
  always_comb begin
    req = bus.in_valid;
    if (locked_q) begin
      req = bus.in_valid & (N'(1) << lock_ch_q);
    end
  end
`else
  assign req = bus.in_valid;
`endif

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign load = !valid_q || bus.out_ready;
  assign xfer = any && load && !rst;

  assign bus.in_ready = xfer ? gnt_onehot : '0;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_onehot[i]) gnt_data = gnt_data | `MUX_SLICE(bus.in_data, i, W);
    end
  end

  assign gnt_last = |(gnt_onehot & bus.in_last);
  assign ptr_next = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      sel_q     <= '0;
      last_q    <= 1'b0;
      ptr_q     <= '0;
`ifdef MUX_RR_LOCK_EN
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else if (load) begin
      if (xfer) begin
        valid_q <= 1'b1;
        data_q  <= gnt_data;
        sel_q   <= gnt_idx;
        last_q  <= gnt_last;
`ifdef MUX_RR_LOCK_EN
        if (gnt_last) begin
          locked_q <= 1'b0;
          ptr_q    <= ptr_next;
        end else begin
          locked_q  <= 1'b1;
          lock_ch_q <= gnt_idx;
        end
`else
        ptr_q   <= ptr_next;
`endif
      end else begin
        // Drain: payload registers keep their last value.
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: directed plan scenarios plus randomized traffic against a reference model.
module tb_mux_rr_n;
  import mux_pkg::*;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = clog2(N);
`ifdef MUX_RR_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_n_if #(.N(N), .W(W)) bus ();

  mux_rr_n #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Stimulus state
  logic [N-1:0] v;
  logic [N-1:0] l;
  logic [W-1:0] d [N];
  logic         ordy;
  int           cnt [N];

  // Reference model state
  int m_ptr, m_lk, m_od, m_os;
  bit m_locked, m_ov, m_ol;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic apply();
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = d[i];
  endtask

  // Channel that should be accepted this cycle, or -1.
  function automatic int pick();
    if (rst) return -1;
    if (m_ov && !ordy) return -1;
    if (m_locked) return v[m_lk] ? m_lk : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (rst) begin
      m_ptr = 0; m_lk = 0; m_locked = 0;
      m_ov = 0; m_od = 0; m_os = 0; m_ol = 0;
    end else if (!(m_ov && !ordy)) begin
      if (g >= 0) begin
        m_ov = 1; m_od = int'(d[g]); m_os = g; m_ol = l[g];
        if (LOCK && !l[g]) begin
          m_locked = 1; m_lk = g;
        end else begin
          m_locked = 0; m_ptr = (g + 1) % N;
        end
        cnt[g]++;
      end else begin
        m_ov = 0;
      end
    end
  endtask

  task automatic step();
    int g;
    apply();
    #1;
    g = pick();
    check("in_ready", 32'(bus.in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    model_update(g);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("out_data",  32'(bus.out_data),  32'(m_od));
    check("out_sel",   32'(bus.out_sel),   32'(m_os));
    check("out_last",  32'(bus.out_last),  32'(m_ol));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int lk_exp [4];
    int got_sel [$];
    rst  = 1'b1;
    ordy = 1'b1;
    v    = '0;
    l    = '0;
    for (int i = 0; i < N; i++) begin d[i] = '0; cnt[i] = 0; end
    m_ptr = 0; m_lk = 0; m_locked = 0; m_ov = 0; m_od = 0; m_os = 0; m_ol = 0;

    // Reset with every channel requesting
    v = '1;
    for (int i = 0; i < N; i++) d[i] = W'(8'hA0 + i);
    step();
    step();
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);

    // Full contention: 0,1,2,3,0 with data A0..A3
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("contend_sel",  32'(bus.out_sel),  32'(k % 4));
      check("contend_data", 32'(bus.out_data), 32'(8'hA0 + (k % 4)));
    end

    // Sparse: ch1 and ch3 alternate with no bubbles
    do_reset();
    v = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      check("sparse_valid", 32'(bus.out_valid), 32'd1);
      check("sparse_sel",   32'(bus.out_sel),   (k % 2) ? 32'd3 : 32'd1);
    end

    // Backpressure on a registered ch2/0x55 beat
    do_reset();
    v = 4'b0100;
    d[2] = 8'h55;
    step();
    check("bp_load_sel", 32'(bus.out_sel), 32'd2);
    v    = '1;
    ordy = 1'b0;
    for (int i = 0; i < N; i++) d[i] = W'(8'hA0 + i);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_data",  32'(bus.out_data),  32'h55);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
    end
    ordy = 1'b1;
    step();
    check("bp_release_sel",  32'(bus.out_sel),  32'd3);
    check("bp_release_data", 32'(bus.out_data), 32'hA3);

    // Single requester ch3, then pointer has wrapped to 0
    do_reset();
    v = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      check("single_sel", 32'(bus.out_sel), 32'd3);
    end
    v = '1;
    step();
    check("wrap_sel", 32'(bus.out_sel), 32'd0);

    // Packet: ch0 sends 3 beats (last on 3rd) while ch1 always requests
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    if (LOCK) lk_exp = '{0, 0, 0, 1};
    else      lk_exp = '{0, 1, 0, 1};
    for (int k = 0; k < 8 && got_sel.size() < 4; k++) begin
      v    = {2'b00, 1'b1, (cnt[0] < 3)};
      l    = {2'b00, 1'b1, (cnt[0] == 2)};
      d[0] = W'(8'h10 + cnt[0]);
      d[1] = W'(8'h20 + cnt[1]);
      step();
      if (bus.out_valid) got_sel.push_back(int'(bus.out_sel));
    end
    check("lock_beats", 32'(got_sel.size()), 32'd4);
    for (int k = 0; k < got_sel.size() && k < 4; k++) check("lock_sel", 32'(got_sel[k]), 32'(lk_exp[k]));

    // Randomized traffic, including mid-stream resets and backpressure
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 63) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 2) != 0);
        l[i] = ($urandom_range(0, 2) == 0);
        d[i] = W'(i * 64 + cnt[i]);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

- Registered N-channel, W-bit multiplexer; round-robin arbitration among requesting inputs.
- Valid/ready handshake on every input and on the output.
- Parametrised successor to the 1-bit 2:1 classic mux in the shared components library.
- Merges several producer streams onto one consumer: one beat per cycle, channel index tagged on each beat.

## Interface
- `N`, 4: number of input channels, 2..16.
- `W`, 8: data width per channel, ≥1.
- `SELW`, clog2(N): localparam; width of the channel index.
- Ports below are stated exactly as decided: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  N  per-channel request.
- `in_data`  in  N*W  flattened; channel i occupies bits [i*W +: W].
- `in_last`  in  N  per-channel end-of-packet marker.
- `in_ready`  out  N  one-hot or zero; per-channel accept.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  granted beat.
- `out_sel`  out  SELW  index of the channel that supplied `out_data`.
- `out_last`  out  1  copy of the granted channel's `in_last`.
- `out_ready`  in  1  consumer accepts the current beat.

## Operation
- Reset values (any cycle with `rst`=1, regardless of other inputs):
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `out_last`=0.
  - Round-robin pointer=0, i.e. channel 0 highest priority.
  - Lock flag cleared.
- `load` = !out_valid || out_ready.
- Arbitration (combinational):
  - `grant` = first i with `in_valid[i]`=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - `in_ready[grant]` = `load`; all other `in_ready` bits = 0.
  - No request → `in_ready` = 0.
- Transfer occurs when `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_data` ← `in_data[g]`, `out_sel` ← g, `out_last` ← `in_last[g]`, `out_valid` ← 1.
  - Pointer ← (g+1) mod N; wrap from N-1 to 0.
- Drain: `load`=1 with no transfer → `out_valid` ← 0; `out_data`/`out_sel`/`out_last` hold their previous values.
- Stall: `out_valid`=1 and `out_ready`=0 → all output registers and the pointer hold; every `in_ready` = 0.
- Non-requesting channels are skipped with no bubble; a single requester is granted every cycle.
- Data integrity: no beat dropped or duplicated; per-channel order preserved.
- `rst` asserted mid-stream discards any held beat. No transfer is reported in that cycle, even if `in_valid` is high.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready`, pointer and lock state.
- `out_*` are purely registered.
- Simultaneous drain and load in one cycle is a normal full-rate transfer.
- N=2 must behave as an alternating 2:1 mux when both inputs request continuously.

## Configuration
- `MUX_RR_LOCK_EN` defined: packet lock.
  - After a transfer with `in_last[g]`=0, the grant stays on channel g until a beat with `in_last`=1 transfers.
  - While locked, channel g's `in_valid`=0 produces no grant to any other channel.
  - The pointer advances only on the last beat.
  - Reset clears the lock.
- Macro undefined: `in_last` is only forwarded to `out_last`; every beat re-arbitrates.

## Structure
- Package `mux_pkg` holds:
  - constant function `clog2`;
  - default `N`/`W` constants;
  - slice helper macro for the flattened `in_data` bus.
- Sub-module `rr_arbiter`:
  - parameters N; inputs `req[N]`, `ptr[SELW]`; outputs `gnt_onehot[N]`, `gnt_idx[SELW]`, `any`;
  - purely combinational.
- Output register, pointer and lock logic live in `mux_rr_n`.

## Test plan
- Reset: drive `rst`=1 with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0 during reset; first grant after reset is ch0.
- Full contention: N=4, W=8, all valid, `out_ready`=1, `in_data` = channel index+0xA0 → `out_sel` sequence 0,1,2,3,0…; `out_data` A0,A1,A2,A3.
- Sparse requests: only ch1 and ch3 valid → alternating 1,3,1,3, no idle cycles.
- Backpressure: hold `out_ready`=0 for 3 cycles with beat ch2/0x55 registered → output stable, `in_ready`=0; release → 0x55 consumed once, next grant ch3.
- Wrap and single requester: only ch3 valid for 3 beats → three consecutive grants, pointer wraps to 0.
- Lock (`MUX_RR_LOCK_EN`): ch0 sends 3 beats (`in_last` 0,0,1) while ch1 is valid → `out_sel` 0,0,0,1; without the macro → 0,1,0,1.
